rv_div_unit: RTL and testbench

Iterative RV32M divide unit in the execute stage, directly downstream of the register file. It consumes the two source operands read on rs1Data/rs2Data and implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. It uses a start/busy/done handshake so the pipeline control can stall while a division is in flight.

---
 rtl/rv_div_unit.sv | 120 ++++++++++++
 tb/tb_rv_div_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// start/busy/done handshake; divide-by-zero and signed overflow complete on the accepting edge.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | 32 shift/subtract iterations in flight (busy=1)
// DONE   | one-cycle done pulse, result valid; may accept the next start
module rv_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  dvd, dsr, rem, result_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, rem_sel;

  logic             accept, is_signed, div_zero, overflow, special;
  logic [XLEN-1:0]  spec_res, abs_a, abs_b;
  logic [XLEN:0]    rem_sh;
  logic             ge;
  logic [XLEN-1:0]  sub, rem_nxt, q_nxt, final_res;

  always_comb begin
    accept    = (state != S_CALC) && start && !flush;
    is_signed = !op[0];
    div_zero  = (rs2Data == '0);
    overflow  = is_signed && (rs1Data == INT_MIN) && (rs2Data == '1);
    special   = div_zero || overflow;
    if (div_zero) spec_res = op[1] ? rs1Data : '1;
    else          spec_res = op[1] ? '0 : INT_MIN;
    // INT_MIN negates to itself, which is the correct unsigned magnitude 2^31
    abs_a     = (is_signed && rs1Data[XLEN-1]) ? -rs1Data : rs1Data;
    abs_b     = (is_signed && rs2Data[XLEN-1]) ? -rs2Data : rs2Data;
  end

  // rem can exceed 2^31 for unsigned ops, so the shifted partial remainder keeps a 33rd bit
  always_comb begin
    rem_sh    = {rem, dvd[XLEN-1]};
    ge        = (rem_sh >= {1'b0, dsr});
    sub       = rem_sh[XLEN-1:0] - dsr;
    rem_nxt   = ge ? sub : rem_sh[XLEN-1:0];
    q_nxt     = {dvd[XLEN-2:0], ge};
    if (rem_sel) final_res = neg_r ? -rem_nxt : rem_nxt;
    else         final_res = neg_q ? -q_nxt : q_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = special ? S_DONE : S_CALC;
        else        state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      if (special) result_q <= spec_res;
      dvd     <= abs_a;
      dsr     <= abs_b;
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= is_signed && (rs1Data[XLEN-1] ^ rs2Data[XLEN-1]);
      neg_r   <= is_signed && rs1Data[XLEN-1];
      rem_sel <= op[1];
    end else if (state == S_CALC) begin
      dvd <= q_nxt;
      rem <= rem_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) result_q <= final_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: handshake timing checked inline per task,
// results checked by a done-triggered monitor against a queue of model values.
module tb_rv_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1Data, rs2Data;
  logic        busy, done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_last = 32'h0;

  rv_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b10:   return 32'(sa % sb);
      2'b01:   return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h with no operation outstanding", result);
      end else begin
        exp_last = exp_q.pop_front();
        if (result !== exp_last) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, exp_last);
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that should raise done.
  task automatic run_normal(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_q.push_back(model(o, a, b));
    op = o; rs1Data = a; rs2Data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL calc_busy edge %0d: busy=%b done=%b expected busy=1 done=0", i, busy, done);
      end
      if (poke && i == 5) begin
        start = 1'b1; op = 2'b00; rs1Data = 32'd77; rs2Data = 32'd0;
      end
      if (poke && i == 7) start = 1'b0;
      if (i < 31) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_edge32: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
  endtask

  task automatic run_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(o, a, b));
    op = o; rs1Data = a; rs2Data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL special_done_edge0: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (is_special(o, a, b)) run_special(o, a, b);
    else                     run_normal(o, a, b, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic idle_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL quiet cycle %0d: busy=%b done=%b expected 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1Data = '0; rs2Data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(2'b00, 32'd100, 32'd7);
    run_op(2'b10, 32'd100, 32'd7);
  endtask

  task automatic test_signs();
    run_op(2'b00, -32'sd7, 32'd2);
    run_op(2'b10, -32'sd7, 32'd2);
    run_op(2'b10, 32'd7, -32'sd2);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b01, 32'h0000_0005, 32'h8000_0000);
  endtask

  task automatic test_special();
    run_op(2'b00, 32'd5, 32'd0);
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h8000_0000, 32'd1);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    // back-to-back specials, each accepted in the previous DONE cycle
    run_special(2'b01, 32'd9, 32'd0);
    run_special(2'b10, 32'd9, 32'd0);
    run_special(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] held;
    held = exp_last;
    op = 2'b00; rs1Data = 32'd1000; rs2Data = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== held) begin
      errors++;
      $display("FAIL flush: busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, held);
    end
    idle_quiet(40);
    run_normal(2'b01, 32'd9, 32'd2, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_normal(2'b00, 32'd100, 32'd7, 1'b0);
    run_normal(2'b00, 32'd20, 32'd4, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    op = 2'b00; rs1Data = 32'd50; rs2Data = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_last = 32'h0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    idle_quiet(40);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      if (i % 4 == 1) a = -a;
      run_op(o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_special();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    test_random();
    idle_quiet(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d results never produced, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
